fc_layer_link: RTL and testbench

- Inter-layer link between two fc_layer stages.
- Consumes the post-activation output stream (o_func_data) of layer N and applies optional ReLU and signed saturation.
- Writes the result sequentially into the input buffer of layer N+1, then pulses that layer's i_start once a full vector is written.
- Drives back-pressure to layer N on its i_next_busy input; a small skid FIFO absorbs in-flight words.

---
 rtl/fc_layer_link.sv | 119 +++++++++++
 tb/tb_fc_layer_link.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_link.sv
// Link between two fc_layer stages: takes layer N's post-activation stream,
// applies optional ReLU plus signed saturation, buffers it in a skid FIFO and
// writes it into layer N+1's input buffer, then pulses that layer's start.
module fc_layer_link #(
  parameter int unsigned layer_size    = 784,
  parameter int unsigned in_width      = 8,
  parameter int unsigned datatype_size = 8,
  parameter int unsigned fifo_depth    = 4,
  parameter bit          relu_en       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_func_valid,
  input  logic [in_width-1:0]           i_func_data,
  output logic                          o_next_busy,
  output logic                          o_ibuf_we,
  output logic [datatype_size-1:0]      o_ibuf_wr_data,
  output logic [$clog2(layer_size)-1:0] o_ibuf_addr,
  output logic                          o_start,
  input  logic                          i_busy,
  output logic                          o_overflow
);

  localparam int unsigned addr_w = $clog2(layer_size);
  localparam int unsigned ptr_w  = $clog2(fifo_depth);
  localparam int unsigned cnt_w  = ptr_w + 1;

  typedef enum logic [1:0] {StFill, StStart, StAck} state_e;

  state_e                   state_q, state_d;
  logic [datatype_size-1:0] fifo_mem [fifo_depth];
  logic [ptr_w-1:0]         wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]         count_q, count_d;
  logic [addr_w-1:0]        counter_q;

  logic                       fifo_empty, fifo_full, push, pop, last_word;
  logic signed [in_width-1:0] relu_val;
  logic [datatype_size-1:0]   conv_val;

  // ReLU on the raw upstream word
  always_comb begin
    relu_val = i_func_data;
    if (relu_en && i_func_data[in_width-1]) relu_val = '0;
  end

  if (in_width > datatype_size) begin : g_sat
    localparam logic signed [in_width-1:0] sat_max =
      signed'(in_width'((1 << (datatype_size - 1)) - 1));
    // Bitwise inverse of 0..0111 is 1..1000, i.e. the most negative output value
    localparam logic signed [in_width-1:0] sat_min = ~sat_max;

    // Signed clamp into the narrower ibuf word
    always_comb begin
      if (relu_val > sat_max)      conv_val = sat_max[datatype_size-1:0];
      else if (relu_val < sat_min) conv_val = sat_min[datatype_size-1:0];
      else                         conv_val = relu_val[datatype_size-1:0];
    end
  end else begin : g_ext
    // Sign-extend into an equal or wider ibuf word
    always_comb conv_val = datatype_size'(relu_val);
  end

  // FIFO flags, handshake decode and FSM next state
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == cnt_w'(fifo_depth));
    pop        = (state_q == StFill) && !fifo_empty && !i_busy;
    // A push into a full FIFO still lands when a pop frees a slot this cycle
    push       = i_func_valid && (!fifo_full || pop);
    last_word  = (counter_q == addr_w'(layer_size - 1));
    count_d    = count_q + cnt_w'(push) - cnt_w'(pop);

    state_d = state_q;
    case (state_q)
      StFill:  if (pop && last_word) state_d = StStart;
      StStart: state_d = StAck;
      StAck:   if (i_busy) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // FIFO storage; pointers reset elsewhere, so contents need no reset
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr_q] <= conv_val;
  end

  // FSM, FIFO pointers and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StFill;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      counter_q      <= '0;
      o_ibuf_we      <= 1'b0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr    <= '0;
      o_start        <= 1'b0;
      o_overflow     <= 1'b0;
      o_next_busy    <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      // Throttle one slot early so the word already in flight still fits
      o_next_busy <= (count_d >= cnt_w'(fifo_depth - 1)) || (state_d != StFill);
      o_ibuf_we   <= pop;
      o_start     <= (state_q == StStart);
      if (push) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + ptr_w'(1);
        o_ibuf_wr_data <= fifo_mem[rd_ptr_q];
        o_ibuf_addr    <= counter_q;
        counter_q      <= last_word ? '0 : counter_q + addr_w'(1);
      end
      if (i_func_valid && fifo_full && !pop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_layer_link.sv
// Bench for fc_layer_link: 8-word vectors, 16-bit input, 8-bit ibuf words.
// Two instances share all inputs: u_dut has ReLU on, u_dut_nr has it off.
module tb_fc_layer_link;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        busy = 1'b0;
  logic [15:0] data = '0;

  logic       nb, we, st, ovf;
  logic [7:0] wd;
  logic [2:0] a;
  logic       nb2, we2, st2, ovf2;
  logic [7:0] wd2;
  logic [2:0] a2;

  fc_layer_link #(
    .layer_size(8), .in_width(16), .datatype_size(8), .fifo_depth(4), .relu_en(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .i_func_valid(valid), .i_func_data(data),
    .o_next_busy(nb), .o_ibuf_we(we), .o_ibuf_wr_data(wd), .o_ibuf_addr(a),
    .o_start(st), .i_busy(busy), .o_overflow(ovf)
  );

  fc_layer_link #(
    .layer_size(8), .in_width(16), .datatype_size(8), .fifo_depth(4), .relu_en(1'b0)
  ) u_dut_nr (
    .clk(clk), .rst(rst), .i_func_valid(valid), .i_func_data(data),
    .o_next_busy(nb2), .o_ibuf_we(we2), .o_ibuf_wr_data(wd2), .o_ibuf_addr(a2),
    .o_start(st2), .i_busy(busy), .o_overflow(ovf2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int wr2_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every ibuf write and start pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (we) begin
      wr_addr.push_back(int'(a));
      wr_data.push_back(int'(wd));
      wr_cyc.push_back(cyc);
    end
    if (we2) wr2_data.push_back(int'(wd2));
    if (st) start_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".we"}, 32'(we), 32'd0);
    chk({nm, ".addr"}, 32'(a), 32'd0);
    chk({nm, ".data"}, 32'(wd), 32'd0);
    chk({nm, ".start"}, 32'(st), 32'd0);
    chk({nm, ".ovf"}, 32'(ovf), 32'd0);
    chk({nm, ".nbusy"}, 32'(nb), 32'd1);
  endtask

  // Wait for o_start, then acknowledge with a busy pulse
  task automatic finish_vector(input string nm);
    int s0;
    int n;
    s0 = start_cnt;
    n = 0;
    while (start_cnt == s0 && n < 60) begin
      step();
      n++;
    end
    chk({nm, ".start_seen"}, 32'(start_cnt - s0), 32'd1);
    step();
    step();
    busy = 1'b1;
    step();
    step();
    busy = 1'b0;
    step();
  endtask

  typedef struct {
    logic       v;
    logic [15:0] d;
    logic       b;
    logic       we;
    logic [2:0] a;
    logic [7:0] wd;
    logic       st;
    logic       nb;
  } vec_t;

  vec_t tbl[13];

  int relu_in[8] = '{'hFF80, 'h0100, 5, 'h7FFF, 'h8000, 'h007F, 'hFF81, 0};
  int exp_r1[8]  = '{0, 'h7F, 5, 'h7F, 0, 'h7F, 0, 0};
  int exp_r0[8]  = '{'h80, 'h7F, 5, 'h7F, 'h80, 'h7F, 'h81, 0};

  initial begin
    int base;
    int base2;
    int idx;
    int stall;
    int s0;
    int resp;
    int nf;
    int fall0;
    logic stall_done;
    logic saw_we;
    logic done;

    // Cycle-accurate basic fill: rows are {v, d, b, we, addr, wdata, start, nbusy}
    tbl[0] = '{1'b1, 16'd1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0};
    for (int i = 1; i < 8; i++)
      tbl[i] = '{1'b1, 16'(i + 1), 1'b0, 1'b1, 3'(i - 1), 8'(i), 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'd0, 1'b0, 1'b1, 3'd7, 8'd8, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0};

    // Reset values
    rst = 1'b1;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      valid = tbl[i].v;
      data  = tbl[i].d;
      busy  = tbl[i].b;
      step();
      chk($sformatf("fill%0d.we", i), 32'(we), 32'(tbl[i].we));
      chk($sformatf("fill%0d.start", i), 32'(st), 32'(tbl[i].st));
      chk($sformatf("fill%0d.nbusy", i), 32'(nb), 32'(tbl[i].nb));
      if (tbl[i].we) begin
        chk($sformatf("fill%0d.addr", i), 32'(a), 32'(tbl[i].a));
        chk($sformatf("fill%0d.data", i), 32'(wd), 32'(tbl[i].wd));
      end
    end
    valid = 1'b0;
    busy  = 1'b0;

    // ReLU and saturation, both ReLU settings
    base  = wr_data.size();
    base2 = wr2_data.size();
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      data  = 16'(relu_in[i]);
      step();
    end
    valid = 1'b0;
    finish_vector("relu");
    chk("relu.count", 32'(wr_data.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("relu_on%0d", i), 32'(wr_data[base + i]), 32'(exp_r1[i]));
      chk($sformatf("relu_off%0d", i), 32'(wr2_data[base2 + i]), 32'(exp_r0[i]));
    end

    // Downstream stall with a producer that honours o_next_busy
    base = wr_addr.size();
    idx = 0;
    stall = 0;
    stall_done = 1'b0;
    saw_we = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!stall_done && stall == 0 && wr_addr.size() - base >= 2) stall = 1;
      busy  = (stall > 0);
      valid = (idx < 8) && !nb;
      data  = 16'h10 + 16'(idx);
      step();
      if (valid) idx++;
      if (stall > 0) begin
        if (we) saw_we = 1'b1;
        if (stall == 10) begin
          chk("stall.nbusy", 32'(nb), 32'd1);
          chk("stall.ovf", 32'(ovf), 32'd0);
          stall = 0;
          stall_done = 1'b1;
        end else begin
          stall++;
        end
      end
      if (idx == 8 && stall_done) break;
    end
    valid = 1'b0;
    busy  = 1'b0;
    chk("stall.done", 32'(stall_done), 32'd1);
    chk("stall.no_write", 32'(saw_we), 32'd0);
    finish_vector("stall");
    chk("stall.count", 32'(wr_addr.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stall.addr%0d", i), 32'(wr_addr[base + i]), 32'(i));
      chk($sformatf("stall.data%0d", i), 32'(wr_data[base + i]), 32'h10 + 32'(i));
    end

    // Overflow: six pushes into a stalled link, ignoring o_next_busy
    base = wr_addr.size();
    busy = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      data  = 16'h21 + 16'(i);
      step();
      if (i == 3) chk("ovf.after4", 32'(ovf), 32'd0);
      if (i == 4) chk("ovf.after5", 32'(ovf), 32'd1);
    end
    valid = 1'b0;
    chk("ovf.no_write", 32'(wr_addr.size() - base), 32'd0);
    // Release and push a fifth word in the same cycle as the first pop
    busy  = 1'b0;
    valid = 1'b1;
    data  = 16'h29;
    step();
    valid = 1'b0;
    repeat (8) step();
    chk("ovf.sticky", 32'(ovf), 32'd1);
    chk("ovf.count", 32'(wr_addr.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ovf.addr%0d", i), 32'(wr_addr[base + i]), 32'(i));
      chk($sformatf("ovf.data%0d", i), 32'(wr_data[base + i]), (i < 4) ? 32'h21 + 32'(i) : 32'h29);
    end

    // Reset mid-vector after five writes
    s0  = start_cnt;
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    repeat (6) step();
    chk("midrst.no_start", 32'(start_cnt - s0), 32'd0);

    // Back-to-back vectors with an auto-acknowledging downstream
    s0 = start_cnt;
    base = wr_addr.size();
    idx = 0;
    resp = 0;
    nf = 0;
    fall0 = 0;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (st) resp = 1;
      else if (resp > 0) resp++;
      busy = (resp >= 3 && resp < 6);
      if (resp == 6) begin
        if (nf == 0) fall0 = cyc;
        nf++;
        resp = 0;
      end
      valid = (idx < 16) && !nb;
      data  = 16'h30 + 16'(idx);
      step();
      if (valid) idx++;
      if (idx == 16 && nf == 2) begin
        done = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    busy  = 1'b0;
    repeat (3) step();
    chk("b2b.done", 32'(done), 32'd1);
    chk("b2b.starts", 32'(start_cnt - s0), 32'd2);
    chk("b2b.count", 32'(wr_addr.size() - base), 32'd16);
    chk("b2b.vec2_after_ack", 32'(wr_cyc[base + 8] > fall0), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b.addr%0d", i), 32'(wr_addr[base + i]), 32'(i % 8));
      chk($sformatf("b2b.data%0d", i), 32'(wr_data[base + i]), 32'h30 + 32'(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
